pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised program-counter sequencer that replaces the plain register-only PC. It selects the next fetch address from several sources: sequential increment, taken branch, jump, or subroutine return. It also supports a fetch stall. A small hardware return-address stack (RAS) holds return addresses for CALL/RET. It sits at the front of the fetch stage and drives the instruction-memory address.

Parameters:
PC_W, 6, width of the PC in bits; arithmetic is modulo 2^PC_W
RESET_VEC, 0, PC value loaded on reset (PC_W bits)
INC, 1, sequential increment, word-addressed instruction memory
RAS_DEPTH, 4, number of return-stack entries (>=2, power of two not required)

Ports:
CLK  input  1  system clock, rising-edge active
RST_N  input  1  asynchronous active-low reset
STALL  input  1  hold the PC and the RAS this cycle
BR_TAKEN  input  1  conditional branch resolved taken
BR_TARGET  input  PC_W  branch destination
JMP  input  1  unconditional jump
JMP_TARGET  input  PC_W  jump destination
CALL  input  1  qualifies JMP as a call; push the return address
RET  input  1  return; pop the RAS
PCO  output  PC_W  current fetch address (registered)
PC_PLUS  output  PC_W  PCO+INC, combinational
RAS_EMPTY  output  1  stack holds 0 entries
RAS_FULL  output  1  stack holds RAS_DEPTH entries
RAS_ERR  output  1  registered one-cycle pulse on underflow or overflow

Behaviour:
- Reset: asserting RST_N low at any time immediately forces the following, regardless of CLK: PCO=RESET_VEC, RAS count=0, RAS_ERR=0. A reset mid-sequence discards all stacked addresses. The first increment happens on the first CLK edge after RST_N deasserts.
- Latency: the control inputs are sampled on a CLK rising edge. The new PCO is visible after that same edge, so the redirect penalty is 1 cycle. PC_PLUS follows PCO combinationally.
- Next-PC priority, highest first:
  - STALL: PCO holds, the RAS is unchanged, RAS_ERR=0. All other inputs are ignored.
  - RET: if the RAS is non-empty, PCO<=top and the RAS pops. If the RAS is empty, PCO<=PC_PLUS and RAS_ERR pulses. JMP/BR_TAKEN/CALL are ignored this cycle.
  - JMP: PCO<=JMP_TARGET. If CALL=1, PC_PLUS is pushed. A push while full drops the oldest entry, keeps the newest RAS_DEPTH entries, and pulses RAS_ERR.
  - BR_TAKEN: PCO<=BR_TARGET.
  - Otherwise: PCO<=PC_PLUS.
- CALL without JMP is ignored and causes no push.
- Wrap: PC_PLUS wraps modulo 2^PC_W; e.g. PC_W=6, PCO=63 gives PC_PLUS=0. A pushed return address is the wrapped value.
- RAS state:
  - Storage is a circular buffer with top pointer and count (0..RAS_DEPTH).
  - RAS_EMPTY = (count==0); RAS_FULL = (count==RAS_DEPTH). Both are derived from registered state.
  - Overflow advances the pointer and keeps the count at RAS_DEPTH.
- RAS_ERR is high for exactly one cycle after the offending edge. It is not sticky.
- No X propagation: the targets are only used when their select is active.

Decomposition:
- Package pc_pkg:
  - next-PC select enum: SEL_HOLD, SEL_SEQ, SEL_BR, SEL_JMP, SEL_RET
  - default width/depth constants
- Sub-module ras_stack (params W, DEPTH):
  - inputs: push, pop, push_data
  - outputs: top, empty, full, overflow, underflow
  - same CLK/RST_N
- The top level holds the priority encoder and the PC register.

Test Plan:
- Reset/sequential: RST_N low mid-run, then release. PCO=0 while low, then 1,2,3 on successive edges. From PCO=63 with PC_W=6, the next edge gives PCO=0.
- Stall: PCO=5, STALL=1 for 3 cycles with JMP=1, JMP_TARGET=20. PCO stays 5 and RAS_EMPTY stays 1. On release with JMP still 1, PCO=20.
- Priority: at PCO=8, RET=1 (RAS holds 30), JMP=1, BR_TAKEN=1, BR_TARGET=12, JMP_TARGET=40. PCO=30 and the RAS is empty. Next cycle, JMP+BR_TAKEN gives PCO=40.
- Nested call/return: CALL+JMP at PCO=2 to 10, then at 10 to 20. RET gives PCO=11, RET again gives PCO=3. RAS_EMPTY=1 afterwards and RAS_ERR never pulses.
- Overflow: with RAS_DEPTH=4, do 5 CALL+JMP from PCO=0,1,2,3,4 (each jumping to the next). RAS_ERR pulses on the 5th and RAS_FULL=1. Five RETs return 5,4,3,2, then PC_PLUS with an RAS_ERR pulse.
- Underflow/reset: RET on an empty stack at PCO=7 gives PCO=8 and a one-cycle RAS_ERR. After 2 pushes, an async RST_N pulse between edges gives PCO=RESET_VEC and RAS_EMPTY=1 immediately.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default sizing for the program-counter sequencer.
package pc_pkg;

   typedef enum logic [2:0] {
      SEL_HOLD,
      SEL_SEQ,
      SEL_BR,
      SEL_JMP,
      SEL_RET
   } pc_sel_e;

   localparam int DEF_PC_W      = 6;
   localparam int DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: pushing onto a full stack overwrites the oldest entry.
module ras_stack
   import pc_pkg::*;
#(
   parameter int W     = DEF_PC_W,
   parameter int DEPTH = DEF_RAS_DEPTH
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] push_data_i,
   output logic [W-1:0] top_o,
   output logic         empty_o,
   output logic         full_o,
   output logic         overflow_o,
   output logic         underflow_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign top_o   = mem_q[ptr_q];

   always_comb begin
      ptr_inc     = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
      ptr_dec     = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - PTR_W'(1);
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      overflow_o  = 1'b0;
      underflow_o = 1'b0;
      if (pop_i) begin
         if (empty_o) begin
            underflow_o = 1'b1;
         end else begin
            ptr_d = ptr_dec;
            cnt_d = cnt_q - CNT_W'(1);
         end
      end else if (push_i) begin
         // A full push still advances the pointer; the count saturates.
         ptr_d = ptr_inc;
         if (full_o) overflow_o = 1'b1;
         else        cnt_d      = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push_i && !pop_i) mem_q[ptr_inc] <= push_data_i;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: priority next-PC select with a hardware return stack.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int              PC_W      = DEF_PC_W,
   parameter logic [PC_W-1:0] RESET_VEC = '0,
   parameter int              INC       = 1,
   parameter int              RAS_DEPTH = DEF_RAS_DEPTH
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            STALL,
   input  logic            BR_TAKEN,
   input  logic [PC_W-1:0] BR_TARGET,
   input  logic            JMP,
   input  logic [PC_W-1:0] JMP_TARGET,
   input  logic            CALL,
   input  logic            RET,
   output logic [PC_W-1:0] PCO,
   output logic [PC_W-1:0] PC_PLUS,
   output logic            RAS_EMPTY,
   output logic            RAS_FULL,
   output logic            RAS_ERR
);

   pc_sel_e         sel;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            err_q, err_d;
   logic            push, pop, ovf, unf;
   logic [PC_W-1:0] ras_top;

   assign PCO     = pc_q;
   assign PC_PLUS = pc_q + PC_W'(INC);
   assign RAS_ERR = err_q;

   always_comb begin
      sel = SEL_SEQ;
      if      (STALL)    sel = SEL_HOLD;
      else if (RET)      sel = SEL_RET;
      else if (JMP)      sel = SEL_JMP;
      else if (BR_TAKEN) sel = SEL_BR;
   end

   always_comb begin
      pc_d = PC_PLUS;
      case (sel)
         SEL_HOLD: pc_d = pc_q;
         SEL_RET:  pc_d = RAS_EMPTY ? PC_PLUS : ras_top;
         SEL_JMP:  pc_d = JMP_TARGET;
         SEL_BR:   pc_d = BR_TARGET;
         default:  pc_d = PC_PLUS;
      endcase
      push  = (sel == SEL_JMP) && CALL;
      pop   = (sel == SEL_RET);
      err_d = ovf | unf;
   end

   ras_stack #(
      .W     (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .push_i      (push),
      .pop_i       (pop),
      .push_data_i (PC_PLUS),
      .top_o       (ras_top),
      .empty_o     (RAS_EMPTY),
      .full_o      (RAS_FULL),
      .overflow_o  (ovf),
      .underflow_o (unf)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pc_q  <= RESET_VEC;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         err_q <= err_d;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with default sizing (PC_W=6, RAS_DEPTH=4).
module tb_pc_sequencer;

   localparam int PC_W = 6;

   logic            CLK = 1'b0;
   logic            RST_N, STALL, BR_TAKEN, JMP, CALL, RET;
   logic [PC_W-1:0] BR_TARGET, JMP_TARGET;
   logic [PC_W-1:0] PCO, PC_PLUS;
   logic            RAS_EMPTY, RAS_FULL, RAS_ERR;

   int checks = 0;
   int errors = 0;

   pc_sequencer #(
      .PC_W      (PC_W),
      .RESET_VEC ('0),
      .INC       (1),
      .RAS_DEPTH (4)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .STALL      (STALL),
      .BR_TAKEN   (BR_TAKEN),
      .BR_TARGET  (BR_TARGET),
      .JMP        (JMP),
      .JMP_TARGET (JMP_TARGET),
      .CALL       (CALL),
      .RET        (RET),
      .PCO        (PCO),
      .PC_PLUS    (PC_PLUS),
      .RAS_EMPTY  (RAS_EMPTY),
      .RAS_FULL   (RAS_FULL),
      .RAS_ERR    (RAS_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1ns past it.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      STALL = 0; BR_TAKEN = 0; JMP = 0; CALL = 0; RET = 0;
      BR_TARGET = '0; JMP_TARGET = '0;
   endtask

   task automatic jump_to(input logic [PC_W-1:0] t, input logic call);
      JMP = 1; CALL = call; JMP_TARGET = t;
      step();
      JMP = 0; CALL = 0;
   endtask

   initial begin
      idle();
      RST_N = 0;
      #12;
      chk("rst_pc", PCO, 0);
      chk("rst_empty", RAS_EMPTY, 1);
      chk("rst_full", RAS_FULL, 0);
      chk("rst_err", RAS_ERR, 0);

      @(posedge CLK); #1;
      RST_N = 1;
      step(); chk("seq1", PCO, 1);
      step(); chk("seq2", PCO, 2);
      step(); chk("seq3", PCO, 3);
      chk("pc_plus3", PC_PLUS, 4);

      // Mid-run reset takes effect between edges.
      #1 RST_N = 0;
      #1 chk("midrst_pc", PCO, 0);
      RST_N = 1;
      step(); chk("midrst_seq", PCO, 1);

      jump_to(6'd63, 0);
      chk("wrap_pc63", PCO, 63);
      chk("wrap_plus", PC_PLUS, 0);
      step(); chk("wrap_pc0", PCO, 0);

      jump_to(6'd5, 0);
      chk("stall_pre", PCO, 5);
      STALL = 1; JMP = 1; JMP_TARGET = 6'd20;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_pc", PCO, 5);
         chk("stall_empty", RAS_EMPTY, 1);
      end
      STALL = 0;
      step(); chk("stall_release", PCO, 20);
      JMP = 0;

      jump_to(6'd29, 0);
      jump_to(6'd8, 1);
      chk("prio_setup_pc", PCO, 8);
      chk("prio_setup_empty", RAS_EMPTY, 0);
      RET = 1; JMP = 1; BR_TAKEN = 1; BR_TARGET = 6'd12; JMP_TARGET = 6'd40;
      step();
      chk("prio_ret_pc", PCO, 30);
      chk("prio_ret_empty", RAS_EMPTY, 1);
      chk("prio_ret_err", RAS_ERR, 0);
      RET = 0;
      step(); chk("prio_jmp_pc", PCO, 40);
      JMP = 0;
      step(); chk("br_pc", PCO, 12);
      BR_TAKEN = 0;

      jump_to(6'd2, 0);
      jump_to(6'd10, 1);
      chk("nest_call1", PCO, 10);
      jump_to(6'd20, 1);
      chk("nest_call2", PCO, 20);
      RET = 1;
      step(); chk("nest_ret1", PCO, 11); chk("nest_err1", RAS_ERR, 0);
      step(); chk("nest_ret2", PCO, 3);  chk("nest_err2", RAS_ERR, 0);
      chk("nest_empty", RAS_EMPTY, 1);
      RET = 0;
      CALL = 1;
      step(); chk("call_nojmp_pc", PCO, 4);
      chk("call_nojmp_empty", RAS_EMPTY, 1);
      CALL = 0;

      jump_to(6'd0, 0);
      for (int i = 0; i < 5; i++) begin
         jump_to(6'(i + 1), 1);
         chk("ovf_pc", PCO, i + 1);
         chk("ovf_err", RAS_ERR, (i == 4) ? 1 : 0);
         chk("ovf_full", RAS_FULL, (i >= 3) ? 1 : 0);
      end
      RET = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("ovf_ret_pc", PCO, 5 - i);
         chk("ovf_ret_err", RAS_ERR, 0);
      end
      step();
      chk("ovf_unf_pc", PCO, 3);
      chk("ovf_unf_err", RAS_ERR, 1);
      RET = 0;
      step();
      chk("err_not_sticky", RAS_ERR, 0);
      chk("after_unf_pc", PCO, 4);

      jump_to(6'd7, 0);
      RET = 1;
      step(); chk("unf_pc", PCO, 8); chk("unf_err", RAS_ERR, 1);
      RET = 0;
      step(); chk("unf_next_pc", PCO, 9); chk("unf_err_clr", RAS_ERR, 0);

      jump_to(6'd15, 1);
      jump_to(6'd15, 1);
      chk("push2_empty", RAS_EMPTY, 0);
      #2 RST_N = 0;
      #1;
      chk("async_pc", PCO, 0);
      chk("async_empty", RAS_EMPTY, 1);
      chk("async_err", RAS_ERR, 0);
      RST_N = 1;
      step(); chk("async_seq", PCO, 1);
      chk("async_still_empty", RAS_EMPTY, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
